// File: rtl/soc_periph_addr_decoder.sv
// Request decode stage in front of the SoC peripheral crossbar: registers one request,
// tags it with its slave index, forwards hits and retires misses locally with DECERR.
module soc_periph_addr_decoder #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] ErrData   = DataWidth'(64'h0000_0000_BADC_AB1E),
  parameter int unsigned          CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [AddrWidth-1:0] mst_addr_o,
  output logic                 mst_write_o,
  output logic [IdWidth-1:0]   mst_id_o,
  output logic [3:0]           mst_idx_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdWidth-1:0]   rsp_id_o,
  output logic                 rsp_write_o,
  output logic [1:0]           rsp_resp_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic [AddrWidth-1:0] err_addr_o
);

  localparam int unsigned NumRules = 13;
  localparam int unsigned IdxWidth = 4;
  localparam int unsigned MapWidth = 64;

  localparam logic [MapWidth-1:0] RuleBase [NumRules] = '{
    64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
    64'h1C00_0000, 64'h1A10_0000, 64'h1800_0000, 64'h2000_0000, 64'h3000_0000,
    64'h4000_0000, 64'h1040_0000, 64'h8000_0000
  };
  localparam logic [MapWidth-1:0] RuleLen [NumRules] = '{
    64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0040_0000,
    64'h0001_0000, 64'h0012_3000, 64'h0000_1000, 64'h0080_0000, 64'h0001_0000,
    64'h0000_1000, 64'h0010_0000, 64'h2000_0000
  };

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HIT,
    ST_MISS
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [CntWidth-1:0]    err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]   err_addr_q, err_addr_d;

  logic [MapWidth-1:0]    dec_addr;
  logic                   dec_hit;
  logic [IdxWidth-1:0]    dec_idx;
  logic                   mst_hs;
  logic                   rsp_hs;
  logic                   accept;

  // Range decode over the full address; rules never overlap, so at most one matches.
  always_comb begin
    dec_addr = MapWidth'(req_addr_i);
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int unsigned i = 0; i < NumRules; i++) begin
      if ((dec_addr >= RuleBase[i]) && (dec_addr < (RuleBase[i] + RuleLen[i]))) begin
        dec_hit = 1'b1;
        dec_idx = IdxWidth'(i);
      end
    end
  end

  assign mst_hs      = (state_q == ST_HIT) && mst_ready_i;
  assign rsp_hs      = (state_q == ST_MISS) && rsp_ready_i;
  assign req_ready_o = !rst_i && ((state_q == ST_EMPTY) || mst_hs || rsp_hs);
  assign accept      = req_valid_i && req_ready_o;

  // Slot control: drain and refill may happen in the same cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    id_d       = id_q;
    idx_d      = idx_q;
    data_d     = data_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;

    if (mst_hs || rsp_hs) begin
      state_d = ST_EMPTY;
    end

    if (accept) begin
      state_d = dec_hit ? ST_HIT : ST_MISS;
      addr_d  = req_addr_i;
      write_d = req_write_i;
      id_d    = req_id_i;
      idx_d   = dec_hit ? dec_idx : '0;
      data_d  = (!dec_hit && !req_write_i) ? ErrData : '0;
      if (!dec_hit) begin
        err_addr_d = req_addr_i;
      end
    end

    if (rsp_hs && (err_cnt_q != {CntWidth{1'b1}})) begin
      err_cnt_d = err_cnt_q + CntWidth'(1);
    end

    if (clr_i) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      addr_q     <= '0;
      write_q    <= 1'b0;
      id_q       <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign mst_valid_o = (state_q == ST_HIT);
  assign mst_addr_o  = addr_q;
  assign mst_write_o = write_q;
  assign mst_id_o    = id_q;
  assign mst_idx_o   = idx_q;

  assign rsp_valid_o = (state_q == ST_MISS);
  assign rsp_id_o    = id_q;
  assign rsp_write_o = write_q;
  assign rsp_resp_o  = 2'b11;
  assign rsp_data_o  = data_q;

  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_soc_periph_addr_decoder.sv
// Directed bench for soc_periph_addr_decoder with a queue scoreboard of expected
// downstream/error responses and immediate assertions at every comparison.
module tb_soc_periph_addr_decoder;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] ERR_DATA = 64'h0000_0000_BADC_AB1E;

  logic          clk_i = 1'b0;
  logic          rst_i, clr_i;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [IW-1:0] req_id_i;
  logic          mst_valid_o, mst_ready_i, mst_write_o;
  logic [AW-1:0] mst_addr_o;
  logic [IW-1:0] mst_id_o;
  logic [3:0]    mst_idx_o;
  logic          rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [IW-1:0] rsp_id_o;
  logic [1:0]    rsp_resp_o;
  logic [DW-1:0] rsp_data_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] err_addr_o;

  soc_periph_addr_decoder #(
    .AddrWidth(AW), .IdWidth(IW), .DataWidth(DW), .ErrData(ERR_DATA), .CntWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_id_i(req_id_i),
    .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i), .mst_addr_o(mst_addr_o),
    .mst_write_o(mst_write_o), .mst_id_o(mst_id_o), .mst_idx_o(mst_idx_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_write_o(rsp_write_o), .rsp_resp_o(rsp_resp_o), .rsp_data_o(rsp_data_o),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          hit;
    logic [3:0]    idx;
    logic [IW-1:0] id;
    logic          wr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference address map written as explicit [start, end) windows.
  function automatic void ref_decode(input logic [63:0] a, output logic hit, output logic [3:0] idx);
    hit = 1'b1;
    if      (a < 64'h0000_1000)                              idx = 4'd0;
    else if (a >= 64'h0001_0000 && a < 64'h0002_0000)        idx = 4'd1;
    else if (a >= 64'h0200_0000 && a < 64'h020C_0000)        idx = 4'd2;
    else if (a >= 64'h0C00_0000 && a < 64'h0FFF_FFFF)        idx = 4'd3;
    else if (a >= 64'h1000_0000 && a < 64'h1040_0000)        idx = 4'd4;
    else if (a >= 64'h1C00_0000 && a < 64'h1C01_0000)        idx = 4'd5;
    else if (a >= 64'h1A10_0000 && a < 64'h1A22_3000)        idx = 4'd6;
    else if (a >= 64'h1800_0000 && a < 64'h1800_1000)        idx = 4'd7;
    else if (a >= 64'h2000_0000 && a < 64'h2080_0000)        idx = 4'd8;
    else if (a >= 64'h3000_0000 && a < 64'h3001_0000)        idx = 4'd9;
    else if (a >= 64'h4000_0000 && a < 64'h4000_1000)        idx = 4'd10;
    else if (a >= 64'h1040_0000 && a < 64'h1050_0000)        idx = 4'd11;
    else if (a >= 64'h8000_0000 && a < 64'hA000_0000)        idx = 4'd12;
    else begin
      hit = 1'b0;
      idx = 4'd0;
    end
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] a, input logic wr, input logic [IW-1:0] id);
    exp_t e;
    ref_decode(a, e.hit, e.idx);
    e.id   = id;
    e.wr   = wr;
    e.addr = a;
    return e;
  endfunction

  // Present one request, wait (bounded) for acceptance, record its expected result.
  task automatic send(input logic [63:0] a, input logic wr, input logic [IW-1:0] id, output int waits);
    req_addr_i  = a;
    req_write_i = wr;
    req_id_i    = id;
    req_valid_i = 1'b1;
    waits = 0;
    @(negedge clk_i);
    while (!req_ready_o && waits < 100) begin
      waits++;
      @(negedge clk_i);
    end
    if (!req_ready_o) chk("accept_timeout", 64'(req_ready_o), 64'd1);
    sb.push_back(mk_exp(a, wr, id));
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every downstream or error-response handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("mutex_valids", 64'(mst_valid_o & rsp_valid_o), 64'd0);
      if (mst_valid_o && mst_ready_i) begin
        if (sb.size() == 0) chk("sb_underflow_mst", 64'(sb.size()), 64'd1);
        else begin
          mon_e = sb.pop_front();
          chk("mst_is_hit", 64'(mon_e.hit), 64'd1);
          chk("mst_idx", 64'(mst_idx_o), 64'(mon_e.idx));
          chk("mst_id", 64'(mst_id_o), 64'(mon_e.id));
          chk("mst_write", 64'(mst_write_o), 64'(mon_e.wr));
          chk("mst_addr", mst_addr_o, mon_e.addr);
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) chk("sb_underflow_rsp", 64'(sb.size()), 64'd1);
        else begin
          mon_e = sb.pop_front();
          chk("rsp_is_miss", 64'(mon_e.hit), 64'd0);
          chk("rsp_id", 64'(rsp_id_o), 64'(mon_e.id));
          chk("rsp_write", 64'(rsp_write_o), 64'(mon_e.wr));
          chk("rsp_resp", 64'(rsp_resp_o), 64'd3);
          chk("rsp_data", rsp_data_o, mon_e.wr ? 64'd0 : ERR_DATA);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, w2;
    logic [63:0] stream_a [4];
    logic [3:0]  stream_i [4];
    logic [63:0] bnd_a [5];
    logic        bnd_h [5];
    logic [3:0]  bnd_i [5];

    stream_a = '{64'h0, 64'h1_FFFF, 64'h0C00_0000, 64'h9FFF_FFFF};
    stream_i = '{4'd0, 4'd1, 4'd3, 4'd12};
    bnd_a = '{64'h0FFF_FFFF, 64'h1000_0000, 64'hA000_0000, 64'h1_8000_0000, 64'h1A22_2FFF};
    bnd_h = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bnd_i = '{4'd0, 4'd4, 4'd0, 4'd0, 4'd6};

    rst_i = 1'b1; clr_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    req_write_i = 1'b0; req_id_i = '0; mst_ready_i = 1'b0; rsp_ready_i = 1'b0;

    // Reset values
    #12;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_mst_valid", 64'(mst_valid_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("rst_err_addr", err_addr_o, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready_o), 64'd1);
    mst_ready_i = 1'b1;
    rsp_ready_i = 1'b1;

    // Single read hit to UART, one-cycle latency
    send(64'h4000_0010, 1'b0, 5'd7, w);
    chk("t1_mst_valid", 64'(mst_valid_o), 64'd1);
    chk("t1_idx", 64'(mst_idx_o), 64'd10);
    chk("t1_id", 64'(mst_id_o), 64'd7);
    chk("t1_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(posedge clk_i); #1;
    chk("t1_drained", 64'(mst_valid_o), 64'd0);

    // Read miss held under error-response backpressure
    rsp_ready_i = 1'b0;
    send(64'h7000_0000, 1'b0, 5'd5, w);
    for (int c = 0; c < 4; c++) begin
      chk("miss_rsp_valid", 64'(rsp_valid_o), 64'd1);
      chk("miss_mst_valid", 64'(mst_valid_o), 64'd0);
      chk("miss_resp", 64'(rsp_resp_o), 64'd3);
      chk("miss_data", rsp_data_o, 64'hBADC_AB1E);
      chk("miss_id", 64'(rsp_id_o), 64'd5);
      chk("miss_req_ready", 64'(req_ready_o), 64'd0);
      if (c < 3) begin
        @(posedge clk_i); #1;
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("miss_err_cnt", 64'(err_cnt_o), 64'd1);
    chk("miss_err_addr", err_addr_o, 64'h7000_0000);
    chk("miss_drained", 64'(rsp_valid_o), 64'd0);

    // Back-to-back hits, no bubbles
    for (int i = 0; i < 4; i++) begin
      send(stream_a[i], 1'b0, IW'(i + 1), w);
      chk("stream_no_bubble", 64'(w), 64'd0);
      chk("stream_idx", 64'(mst_idx_o), 64'(stream_i[i]));
    end

    // Address-map boundaries
    for (int i = 0; i < 5; i++) begin
      send(bnd_a[i], 1'b1, IW'(i + 16), w);
      chk("bnd_mst_valid", 64'(mst_valid_o), 64'(bnd_h[i]));
      chk("bnd_rsp_valid", 64'(rsp_valid_o), 64'(!bnd_h[i]));
      if (bnd_h[i]) chk("bnd_idx", 64'(mst_idx_o), 64'(bnd_i[i]));
    end
    chk("bnd_err_cnt", 64'(err_cnt_o), 64'd4);
    chk("bnd_err_addr", err_addr_o, 64'h1_8000_0000);

    // Downstream stall with a second request waiting
    @(posedge clk_i); #1;
    mst_ready_i = 1'b0;
    send(64'h2000_0100, 1'b1, 5'd9, w);
    fork
      send(64'h3000_0040, 1'b0, 5'd10, w2);
      begin
        repeat (5) begin
          @(negedge clk_i);
          chk("stall_req_ready", 64'(req_ready_o), 64'd0);
          chk("stall_mst_valid", 64'(mst_valid_o), 64'd1);
          chk("stall_addr", mst_addr_o, 64'h2000_0100);
          chk("stall_id", 64'(mst_id_o), 64'd9);
          chk("stall_idx", 64'(mst_idx_o), 64'd8);
          chk("stall_write", 64'(mst_write_o), 64'd1);
        end
        @(posedge clk_i); #1;
        mst_ready_i = 1'b1;
      end
    join
    chk("stall_waited", 64'(w2 >= 5), 64'd1);
    chk("stall_second_addr", mst_addr_o, 64'h3000_0040);
    chk("stall_second_idx", 64'(mst_idx_o), 64'd9);
    @(posedge clk_i); #1;
    chk("stall_drained", 64'(mst_valid_o), 64'd0);

    // Clear, then saturate the miss counter
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    chk("clr_cnt", 64'(err_cnt_o), 64'd0);
    chk("clr_addr", err_addr_o, 64'd0);
    for (int i = 0; i < 65535; i++) send(64'h7000_0000 + 64'(i), 1'b0, IW'(i), w);
    @(posedge clk_i); #1;
    chk("sat_cnt", 64'(err_cnt_o), 64'hFFFF);
    send(64'h7FFF_0000, 1'b1, 5'd2, w);
    @(posedge clk_i); #1;
    chk("sat_hold", 64'(err_cnt_o), 64'hFFFF);

    // Clear coincident with an error handshake and a new miss capture
    rsp_ready_i = 1'b0;
    send(64'h7100_0000, 1'b1, 5'd3, w);
    rsp_ready_i = 1'b1;
    clr_i = 1'b1;
    req_addr_i = 64'h5000_0000; req_write_i = 1'b0; req_id_i = 5'd4; req_valid_i = 1'b1;
    #1;
    chk("clrhs_req_ready", 64'(req_ready_o), 64'd1);
    sb.push_back(mk_exp(64'h5000_0000, 1'b0, 5'd4));
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("clrhs_cnt", 64'(err_cnt_o), 64'd0);
    chk("clrhs_addr", err_addr_o, 64'd0);
    chk("clrhs_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("clrhs_rsp_id", 64'(rsp_id_o), 64'd4);

    // Asynchronous reset while holding a miss
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("arst_req_ready", 64'(req_ready_o), 64'd0);
    chk("arst_rsp_data", rsp_data_o, 64'd0);
    chk("arst_mst_addr", mst_addr_o, 64'd0);
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("arst_rel_ready", 64'(req_ready_o), 64'd1);
    chk("arst_rel_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("arst_rel_mst_valid", 64'(mst_valid_o), 64'd0);

    // Recovery transaction
    rsp_ready_i = 1'b1;
    send(64'h1800_0004, 1'b0, 5'd1, w);
    chk("recover_idx", 64'(mst_idx_o), 64'd7);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
